// File: rtl/mem_port_arbiter.sv
`default_nettype none
// =============================================================================
// mem_port_arbiter : two-requester round-robin arbiter onto one memory port,
//                    with a per-transaction wait-state timeout.
// Revision 1.0
// =============================================================================
module mem_port_arbiter #(
  parameter logic PRIO_INIT = 1'b0,
  parameter int   WAIT_MAX  = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic [31:0] ADDR0,
  input  logic [31:0] ADDR1,
  input  logic [31:0] WDATA0,
  input  logic [31:0] WDATA1,
  input  logic        WE0,
  input  logic        WE1,
  output logic        ACK0,
  output logic        ACK1,
  output logic        ERR0,
  output logic        ERR1,
  output logic [31:0] RDATA,
  output logic        MEM_VALID,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic        MEM_WE,
  input  logic        MEM_READY,
  input  logic [31:0] MEM_RDATA,
  output logic        SEL
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_BUSY0 = 2'd1;
  localparam logic [1:0] c_BUSY1 = 2'd2;
  localparam logic [7:0] c_WAIT_MAX = WAIT_MAX[7:0];

  logic [1:0] state_q, state_d;
  logic       sel_q, sel_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;

  logic w_busy;
  logic w_done;
  logic w_timeout;
  logic w_grant;

  assign w_busy = (state_q == c_BUSY0) || (state_q == c_BUSY1);

  // A reset landing mid-transaction suppresses the completion/timeout pulse.
  assign w_done    = w_busy && MEM_READY && !RST;
  assign w_timeout = w_busy && !MEM_READY && (cnt_q == c_WAIT_MAX) && !RST;

  assign w_grant = (REQ0 && REQ1) ? ~last_q : REQ1;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_IDLE: begin
        if (REQ0 || REQ1) begin
          sel_d   = w_grant;
          state_d = w_grant ? c_BUSY1 : c_BUSY0;
          cnt_d   = 8'd0;
        end
      end
      c_BUSY0, c_BUSY1: begin
        if (MEM_READY || (cnt_q == c_WAIT_MAX)) begin
          state_d = c_IDLE;
          last_d  = (state_q == c_BUSY1);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= c_IDLE;
      sel_q   <= PRIO_INIT;
      last_q  <= ~PRIO_INIT;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign SEL       = sel_q;
  assign MEM_VALID = w_busy;
  assign MEM_ADDR  = sel_q ? ADDR1  : ADDR0;
  assign MEM_WDATA = sel_q ? WDATA1 : WDATA0;
  assign MEM_WE    = sel_q ? WE1    : WE0;
  assign RDATA     = MEM_RDATA;

  assign ACK0 = w_done    && (state_q == c_BUSY0);
  assign ACK1 = w_done    && (state_q == c_BUSY1);
  assign ERR0 = w_timeout && (state_q == c_BUSY0);
  assign ERR1 = w_timeout && (state_q == c_BUSY1);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// =============================================================================
// tb_mem_port_arbiter : directed scenarios plus randomized traffic checked
//                       against a transaction-level reference model.
// Revision 1.0
// =============================================================================
module tb_mem_port_arbiter;

  localparam logic c_PRIO_INIT = 1'b0;
  localparam int   c_WAIT_MAX  = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, mem_ready;
  logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;
  logic        ack0, ack1, err0, err1, mem_valid, mem_we, sel;
  logic [31:0] rdata, mem_addr, mem_wdata;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the port (-1 = nobody), which cycle of the
  // transaction we are in (1-based), grant select and last-served requester.
  int m_owner;
  int m_k;
  bit m_sel;
  bit m_last;

  int  cnt_ack0, cnt_ack1, cnt_err0, cnt_err1, cnt_valid;
  bit  grants[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.PRIO_INIT(c_PRIO_INIT), .WAIT_MAX(c_WAIT_MAX)) u_dut (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .REQ1(req1),
    .ADDR0(addr0), .ADDR1(addr1),
    .WDATA0(wdata0), .WDATA1(wdata1),
    .WE0(we0), .WE1(we1),
    .ACK0(ack0), .ACK1(ack1), .ERR0(err0), .ERR1(err1),
    .RDATA(rdata),
    .MEM_VALID(mem_valid), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_WE(mem_we),
    .MEM_READY(mem_ready), .MEM_RDATA(mem_rdata),
    .SEL(sel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_counts();
    cnt_ack0 = 0; cnt_ack1 = 0; cnt_err0 = 0; cnt_err1 = 0; cnt_valid = 0;
    grants.delete();
  endtask

  // Inputs are already driven (just after a falling edge); compare outputs,
  // advance the model across the coming rising edge, move to the next falling edge.
  task automatic step();
    logic e_ack0, e_ack1, e_err0, e_err1;
    bit   timed_out;
    int   win;
    #1;
    timed_out = (m_k == c_WAIT_MAX + 1) && !mem_ready;
    e_ack0 = (m_owner == 0) && mem_ready && !rst;
    e_ack1 = (m_owner == 1) && mem_ready && !rst;
    e_err0 = (m_owner == 0) && timed_out && !rst;
    e_err1 = (m_owner == 1) && timed_out && !rst;
    check("mem_valid", 32'(mem_valid), 32'(m_owner >= 0));
    check("sel",       32'(sel),       32'(m_sel));
    check("mem_addr",  mem_addr,  m_sel ? addr1  : addr0);
    check("mem_wdata", mem_wdata, m_sel ? wdata1 : wdata0);
    check("mem_we",    32'(mem_we),    32'(m_sel ? we1 : we0));
    check("rdata",     rdata,     mem_rdata);
    check("ack0",      32'(ack0),      32'(e_ack0));
    check("ack1",      32'(ack1),      32'(e_ack1));
    check("err0",      32'(err0),      32'(e_err0));
    check("err1",      32'(err1),      32'(e_err1));

    cnt_ack0  += int'(ack0);
    cnt_ack1  += int'(ack1);
    cnt_err0  += int'(err0);
    cnt_err1  += int'(err1);
    cnt_valid += int'(mem_valid);
    if (ack0 || ack1) grants.push_back(sel);

    if (rst) begin
      m_owner = -1; m_k = 0; m_sel = c_PRIO_INIT; m_last = ~c_PRIO_INIT;
    end else if (m_owner < 0) begin
      win = -1;
      if (req0 && req1)  win = m_last ? 0 : 1;
      else if (req0)     win = 0;
      else if (req1)     win = 1;
      if (win >= 0) begin
        m_owner = win; m_sel = (win == 1); m_k = 1;
      end
    end else if (mem_ready || m_k == c_WAIT_MAX + 1) begin
      m_last  = (m_owner == 1);
      m_owner = -1;
    end else begin
      m_k++;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int p_ready;
    quiet();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_owner = -1; m_k = 0; m_sel = c_PRIO_INIT; m_last = ~c_PRIO_INIT;

    // Single read from requester 0, released during BUSY.
    do_reset();
    clear_counts();
    req0 = 1'b1; addr0 = 32'h100; addr1 = 32'h200; we0 = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    req0 = 1'b0;
    check("single_rdata", rdata, 32'hDEADBEEF);
    step();
    step();
    check("single_valid_cycles", 32'(cnt_valid), 32'd1);
    check("single_ack0_count",   32'(cnt_ack0),  32'd1);

    // Fairness: both requesting, memory always ready.
    do_reset();
    clear_counts();
    req0 = 1'b1; req1 = 1'b1; mem_ready = 1'b1;
    addr0 = 32'hA0; addr1 = 32'hB1; wdata0 = 32'h11; wdata1 = 32'h22; we0 = 1'b1; we1 = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("rr_grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      check($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));

    // Timeout on requester 1.
    do_reset();
    clear_counts();
    req1 = 1'b1; addr1 = 32'h300;
    step();
    req1 = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("to_err1_count", 32'(cnt_err1), 32'd1);
    check("to_ack1_count", 32'(cnt_ack1), 32'd0);
    check("to_busy_cycles", 32'(cnt_valid), 32'(c_WAIT_MAX + 1));

    // Ready arrives exactly in the timeout cycle.
    do_reset();
    clear_counts();
    req0 = 1'b1; addr0 = 32'h400;
    step();
    req0 = 1'b0;
    for (int i = 0; i < c_WAIT_MAX; i++) step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    check("tie_ack0_count", 32'(cnt_ack0), 32'd1);
    check("tie_err0_count", 32'(cnt_err0), 32'd0);

    // Reset while requester 1 is in flight.
    do_reset();
    clear_counts();
    req1 = 1'b1; addr1 = 32'h500;
    step();
    req1 = 1'b0;
    step();
    rst = 1'b1; mem_ready = 1'b1;
    step();
    rst = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("rst_ack1_count", 32'(cnt_ack1), 32'd0);
    check("rst_err1_count", 32'(cnt_err1), 32'd0);

    // Randomized traffic, alternating fast and slow memory phases.
    for (int blk = 0; blk < 15; blk++) begin
      p_ready = (blk % 2 == 0) ? 50 : 4;
      for (int c = 0; c < 200; c++) begin
        rst       = ($urandom_range(0, 127) == 0);
        req0      = ($urandom_range(0, 2) != 0);
        req1      = ($urandom_range(0, 2) != 0);
        we0       = 1'($urandom_range(0, 1));
        we1       = 1'($urandom_range(0, 1));
        addr0     = $urandom;
        addr1     = $urandom;
        wdata0    = $urandom;
        wdata1    = $urandom;
        mem_rdata = $urandom;
        mem_ready = ($urandom_range(0, 99) < p_ready);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
